// File: rtl/pipeline_stage_reg.sv
// -----------------------------------------------------------------------------
// pipeline_stage_reg
//
// Generic handshaked pipeline register for the core dataflow. It replaces
// the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers: the caller packs any
// stage struct into Width bits. Adds valid/ready flow control, a dominant
// synchronous flush and an optional 2-entry skid buffer.
//
// With SkidEn=1, in_ready comes straight from a state flop, so a stall
// downstream never forms a combinational ready chain across stages. With
// SkidEn=0 the stage holds a single entry and in_ready depends
// combinationally on out_ready (!out_valid | out_ready).
//
// Parameters
//   Width       payload width in bits (packed stage struct)
//   SkidEn      1: 2-entry skid buffer, registered in_ready; 0: single entry
//   BubbleValue value driven on out_data while out_valid=0 (NOP bubble)
//
// Ports
//   clock      in   1      core clock, all state on rising edge
//   reset_n    in   1      asynchronous, active-low reset
//   flush      in   1      discard all held entries (branch/trap redirect)
//   in_valid   in   1      upstream presents in_data
//   in_ready   out  1      stage accepts in_data this cycle
//   in_data    in   Width  upstream payload
//   out_valid  out  1      out_data holds a valid entry
//   out_ready  in   1      downstream consumes out_data this cycle
//   out_data   out  Width  payload to the next stage
//   level      out  2      held entries: 0..2 (0..1 when SkidEn=0)
// -----------------------------------------------------------------------------
module pipeline_stage_reg #(
  parameter int unsigned      Width       = 64,
  parameter bit               SkidEn      = 1'b1,
  parameter logic [Width-1:0] BubbleValue = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data,
  output logic [1:0]       level
);

  // State encoding is {main_v, skid_v}, so the valid bits fall straight out
  // of the state register. skid_v is only ever set while main_v is set.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b10,
    ST_SKID  = 2'b11
  } state_t;

  state_t state_q, state_d;

  logic main_v;
  logic skid_v;
  logic accept;
  logic consume;

  // Datapath load strobes produced by the next-state logic.
  logic load_main_in;
  logic load_main_skid;
  logic load_skid_in;

  logic [Width-1:0] main_q;
  logic [Width-1:0] skid_q;

  assign main_v  = state_q[1];
  assign skid_v  = state_q[0];
  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // Flush wins over everything: both entries are invalidated and an input
  // offered in the same cycle is dropped (no load strobe fires). A consume in
  // the flush cycle still completes downstream; it just leaves nothing behind.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_d      = ST_FULL;
          end
        end

        ST_FULL: begin
          if (accept && consume) begin
            // Old main leaves while the new entry replaces it in place.
            load_main_in = 1'b1;
          end else if (accept && SkidEn) begin
            // Downstream stalled: park the new entry behind main. Without a
            // skid buffer in_ready is low here, so this arm is unreachable.
            load_skid_in = 1'b1;
            state_d      = ST_SKID;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end

        ST_SKID: begin
          // in_ready is low, so only a consume can move things. The parked
          // entry is promoted to main, keeping strict FIFO order.
          if (consume) begin
            load_main_skid = 1'b1;
            state_d        = ST_FULL;
          end
        end

        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid = main_v;
    out_data  = main_v ? main_q : BubbleValue;

    // level = main_v + skid_v, written as a direct decode of the state.
    level = {skid_v, main_v & ~skid_v};

    if (SkidEn) begin
      // Pure flop output: no path from out_ready.
      in_ready = ~skid_v;
    end else begin
      // Single entry: a slot frees up in the same cycle it is consumed, so
      // ready has to look at out_ready combinationally.
      in_ready = ~main_v | out_ready;
    end
  end

  // ---------------------------------------------------------------------------
  // Payload registers
  // ---------------------------------------------------------------------------
  // NOTE: the payload flops carry no reset; the valid bits in the state
  // register already mark them empty and out_data is forced to BubbleValue
  // while out_valid=0, so resetting Width-wide data would only cost routing.
  always_ff @(posedge clock) begin
    if (load_main_in) begin
      main_q <= in_data;
    end else if (load_main_skid) begin
      main_q <= skid_q;
    end

    if (load_skid_in) begin
      skid_q <= in_data;
    end
  end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stage_reg
//
// Drives one skid-buffered instance (SkidEn=1, non-zero bubble) and one
// single-entry instance (SkidEn=0, default bubble) from the same stimulus.
// Each instance has its own queue-based reference: entries are pushed when
// the reference predicts an accept and popped when it predicts a consume;
// every cycle the head of the queue must be on out_data.
// -----------------------------------------------------------------------------
module tb_pipeline_stage_reg;

  localparam int unsigned W       = 64;
  localparam logic [W-1:0] BUBBLE1 = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [W-1:0] BUBBLE0 = '0;

  logic         clock;
  logic         reset_n;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;

  logic         in_ready1, out_valid1;
  logic [W-1:0] out_data1;
  logic [1:0]   level1;

  logic         in_ready0, out_valid0;
  logic [W-1:0] out_data0;
  logic [1:0]   level0;

  pipeline_stage_reg #(
    .Width      (W),
    .SkidEn     (1'b1),
    .BubbleValue(BUBBLE1)
  ) dut_skid (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready1),
    .in_data  (in_data),
    .out_valid(out_valid1),
    .out_ready(out_ready),
    .out_data (out_data1),
    .level    (level1)
  );

  pipeline_stage_reg #(
    .Width      (W),
    .SkidEn     (1'b0),
    .BubbleValue(BUBBLE0)
  ) dut_single (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready0),
    .in_data  (in_data),
    .out_valid(out_valid0),
    .out_ready(out_ready),
    .out_data (out_data0),
    .level    (level0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference queues: depth 2 for the skid instance, depth 1 for single.
  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];
  logic acc1, con1, acc0, con0;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare both instances against their references at the negative edge
  // and latch the predicted handshakes for the coming rising edge.
  task automatic sample();
    logic [W-1:0] head1, head0;
    @(negedge clock);
    head1 = (q1.size() != 0) ? q1[0] : BUBBLE1;
    head0 = (q0.size() != 0) ? q0[0] : BUBBLE0;
    check("skid_out_valid", W'(out_valid1), W'(q1.size() != 0));
    check("skid_out_data",  out_data1,      head1);
    check("skid_level",     W'(level1),     W'(q1.size()));
    check("skid_in_ready",  W'(in_ready1),  W'(q1.size() < 2));
    check("single_out_valid", W'(out_valid0), W'(q0.size() != 0));
    check("single_out_data",  out_data0,      head0);
    check("single_level",     W'(level0),     W'(q0.size()));
    check("single_in_ready",  W'(in_ready0),  W'(q0.size() == 0 || out_ready));
    acc1 = in_valid && (q1.size() < 2);
    con1 = (q1.size() != 0) && out_ready;
    acc0 = in_valid && (q0.size() == 0 || out_ready);
    con0 = (q0.size() != 0) && out_ready;
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
    if (flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (con1) void'(q1.pop_front());
      if (acc1) q1.push_back(in_data);
      if (con0) void'(q0.pop_front());
      if (acc0) q0.push_back(in_data);
    end
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] d,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Table vectors for the skid instance: inputs for the cycle plus the
  // outputs expected before that cycle's rising edge.
  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic [1:0]   lvl;
    logic         ov;
    logic [W-1:0] od;
    logic         ir;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Streaming: one-cycle latency, level steady at 1.
    vecs[0]  = '{1'b1, 64'h1,  1'b1, 2'd0, 1'b0, BUBBLE1, 1'b1};
    vecs[1]  = '{1'b1, 64'h2,  1'b1, 2'd1, 1'b1, 64'h1,   1'b1};
    vecs[2]  = '{1'b1, 64'h3,  1'b1, 2'd1, 1'b1, 64'h2,   1'b1};
    vecs[3]  = '{1'b1, 64'h4,  1'b1, 2'd1, 1'b1, 64'h3,   1'b1};
    vecs[4]  = '{1'b0, 64'h0,  1'b1, 2'd1, 1'b1, 64'h4,   1'b1};
    vecs[5]  = '{1'b0, 64'h0,  1'b1, 2'd0, 1'b0, BUBBLE1, 1'b1};
    // Stall fill: 0x11, 0x22 held, 0x33 refused until a slot frees.
    vecs[6]  = '{1'b1, 64'h11, 1'b0, 2'd0, 1'b0, BUBBLE1, 1'b1};
    vecs[7]  = '{1'b1, 64'h22, 1'b0, 2'd1, 1'b1, 64'h11,  1'b1};
    vecs[8]  = '{1'b1, 64'h33, 1'b0, 2'd2, 1'b1, 64'h11,  1'b0};
    vecs[9]  = '{1'b1, 64'h33, 1'b0, 2'd2, 1'b1, 64'h11,  1'b0};
    vecs[10] = '{1'b1, 64'h33, 1'b1, 2'd2, 1'b1, 64'h11,  1'b0};
    vecs[11] = '{1'b1, 64'h33, 1'b1, 2'd1, 1'b1, 64'h22,  1'b1};
    vecs[12] = '{1'b0, 64'h0,  1'b1, 2'd1, 1'b1, 64'h33,  1'b1};
    vecs[13] = '{1'b0, 64'h0,  1'b1, 2'd0, 1'b0, BUBBLE1, 1'b1};

    reset_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    acc1 = 1'b0; con1 = 1'b0; acc0 = 1'b0; con0 = 1'b0;

    // Reset state while reset is held.
    #3;
    check("rst_out_valid", W'(out_valid1), W'(0));
    check("rst_level",     W'(level1),     W'(0));
    check("rst_out_data",  out_data1,      BUBBLE1);
    check("rst_in_ready",  W'(in_ready1),  W'(1));
    check("rst_single_out_data", out_data0, BUBBLE0);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Table-driven streaming and stall-fill.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, 1'b0);
      sample();
      check($sformatf("vec%0d_level", i),     W'(level1),     W'(vecs[i].lvl));
      check($sformatf("vec%0d_out_valid", i), W'(out_valid1), W'(vecs[i].ov));
      check($sformatf("vec%0d_out_data", i),  out_data1,      vecs[i].od);
      check($sformatf("vec%0d_in_ready", i),  W'(in_ready1),  W'(vecs[i].ir));
      advance();
    end

    // Flush dominance: level 2, flush with a live input of 0x55.
    drive(1'b1, 64'h44, 1'b0, 1'b0); step();
    drive(1'b1, 64'h66, 1'b0, 1'b0); step();
    drive(1'b1, 64'h55, 1'b0, 1'b1);
    sample();
    check("flush_pre_level", W'(level1), W'(2));
    check("flush_pre_in_ready", W'(in_ready1), W'(0));
    advance();
    drive(1'b0, '0, 1'b0, 1'b0);
    sample();
    check("flush_level",     W'(level1),     W'(0));
    check("flush_out_valid", W'(out_valid1), W'(0));
    check("flush_single_out_valid", W'(out_valid0), W'(0));
    advance();
    // Flush while the skid instance is empty-ready: 0x55 offered with
    // in_ready=1 must still be dropped.
    drive(1'b1, 64'h55, 1'b1, 1'b1);
    sample();
    check("flush_in_ready_kept", W'(in_ready1), W'(1));
    advance();
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sample();
      check("flush_no_55", out_data1, BUBBLE1);
      advance();
    end

    // Single-entry instance: combinational ready from out_ready.
    drive(1'b1, 64'h77, 1'b0, 1'b0); step();
    drive(1'b1, 64'h78, 1'b0, 1'b0);
    #1;
    check("single_ready_stalled", W'(in_ready0), W'(0));
    out_ready = 1'b1;
    #1;
    check("single_ready_freed", W'(in_ready0), W'(1));
    step();
    drive(1'b1, 64'h79, 1'b1, 1'b0); step();
    drive(1'b1, 64'h7A, 1'b1, 1'b0);
    sample();
    check("single_throughput", out_data0, 64'h79);
    advance();
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (3) step();

    // Reset mid-SKID: 0xA then 0xB held, then asynchronous reset.
    drive(1'b1, 64'hA, 1'b0, 1'b0); step();
    drive(1'b1, 64'hB, 1'b0, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b0);
    sample();
    check("skid_hold_level", W'(level1),    W'(2));
    check("skid_hold_data",  out_data1,     64'hA);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_out_valid", W'(out_valid1), W'(0));
    check("async_rst_level",     W'(level1),     W'(0));
    check("async_rst_out_data",  out_data1,      BUBBLE1);
    check("async_rst_single_valid", W'(out_valid0), W'(0));
    q1.delete();
    q0.delete();
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    sample();
    check("post_rst_in_ready", W'(in_ready1), W'(1));
    check("post_rst_out_data", out_data1,     BUBBLE1);
    advance();

    // Random valid/ready at 50%, occasional flush.
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom},
            1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
      step();
    end

    // Drain and confirm nothing is left behind.
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (3) step();
    sample();
    check("drain_level", W'(level1), W'(0));
    check("drain_single_level", W'(level0), W'(0));
    advance();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
